ccff_bitstream_loader: RTL and testbench

//   Drives the fabric configuration chains (ccff_head) from a streamed bitstream.
//   - Accepts one bit per chain per beat on a valid/ready stream.
//   - Sequences config_enable and the gated programming-clock enable so every chain shifts in lock-step.
//   - Sits between the SoC bitstream source and fpga_top; it is the writer for the chains.

---
 rtl/ccff_bitstream_loader.sv | 140 ++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_bitstream_loader: streams a bitstream into parallel fabric config    |
// | chains, gating the programming clock so all chains shift in lock-step.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ccff_bitstream_loader #(
  parameter int NUM_CHAINS = 12,
  parameter int CHAIN_LEN  = 2048,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [NUM_CHAINS-1:0] s_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  cfg_clk_en,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [15:0]           stall_cnt
);

  localparam int               SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             launch;
  logic             beat;
  logic             cancel;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort dominates everything, including a start in the same cycle, and
  // masks s_ready so a beat coinciding with abort is never handshaken.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    launch     = 1'b0;
    beat       = 1'b0;
    cancel     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          launch     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else begin
          s_ready = 1'b1;
          beat    = s_valid;
          if (s_valid && (beat_cnt == LAST_BEAT)) begin
            state_next = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else if (settle_cnt == LAST_SETTLE) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state == LOAD) || (state == SETTLE);
  assign config_enable = busy;
  assign done          = (state == DONE);

  // cfg_clk_en is a registered copy of the handshake so the fabric shifts
  // on the edge after ccff_head has been updated with the beat's data.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      ccff_head  <= '0;
      cfg_clk_en <= 1'b0;
      beat_cnt   <= '0;
      settle_cnt <= '0;
      stall_cnt  <= '0;
      aborted    <= 1'b0;
    end else begin
      cfg_clk_en <= beat;

      if (beat) begin
        ccff_head <= s_data;
        beat_cnt  <= beat_cnt + CNT_W'(1);
      end else if (launch) begin
        beat_cnt <= '0;
      end

      if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      if (launch) begin
        stall_cnt <= '0;
      end else if ((state == LOAD) && !s_valid && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      if (cancel) begin
        aborted <= 1'b1;
      end else if (launch) begin
        aborted <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`default_nettype none
// Testbench for ccff_bitstream_loader: table vectors, directed corner cases
// and randomized loads checked against a transaction-level expectation.
module tb_ccff_bitstream_loader;

  localparam int NUM_CHAINS = 12;
  localparam int CHAIN_LEN  = 8;
  localparam int CNT_W      = 3;
  localparam int SETTLE_CYC = 4;

  logic                  prog_clk = 1'b0;
  logic                  pReset   = 1'b1;
  logic                  start    = 1'b0;
  logic                  abort    = 1'b0;
  logic                  s_valid  = 1'b0;
  logic                  s_ready;
  logic [NUM_CHAINS-1:0] s_data   = '0;
  logic [NUM_CHAINS-1:0] ccff_head;
  logic                  cfg_clk_en;
  logic                  config_enable;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [15:0]           stall_cnt;

  int errors = 0;
  int checks = 0;

  ccff_bitstream_loader #(
    .NUM_CHAINS(NUM_CHAINS),
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ccff_head    (ccff_head),
    .cfg_clk_en   (cfg_clk_en),
    .config_enable(config_enable),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .stall_cnt    (stall_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic        st;
    logic        ab;
    logic        v;
    logic [11:0] d;
    logic        rdy;
    logic        cfg;
    logic        ce;
    logic        bsy;
    logic        dn;
    logic        abd;
    logic [11:0] head;
    logic [15:0] stall;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // One full load. mode 0: back-to-back, 1: alternating valid, 2: random valid.
  // Expectations come from counting accepted beats and stalls as they are driven.
  task automatic run_load(input int mode);
    int          beats;
    int          stalls;
    int          pulses;
    int          cyc;
    logic        v;
    logic [11:0] exp_head;
    beats    = 0;
    stalls   = 0;
    pulses   = 0;
    cyc      = 0;
    exp_head = ccff_head;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_entry_cfg_en", 32'(config_enable), 32'd1);
    chk("load_entry_aborted", 32'(aborted), 32'd0);
    chk("load_entry_done", 32'(done), 32'd0);
    chk("load_entry_stall", 32'(stall_cnt), 32'd0);
    while (beats < CHAIN_LEN && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      s_valid = v;
      s_data  = 12'($urandom_range(0, 4095));
      #2;
      chk("load_ready", 32'(s_ready), 32'd1);
      tick();
      cyc++;
      if (v) begin
        beats++;
        exp_head = s_data;
      end else begin
        stalls++;
      end
      chk("load_pulse", 32'(cfg_clk_en), 32'(v));
      chk("load_head", 32'(ccff_head), 32'(exp_head));
      if (cfg_clk_en) pulses++;
    end
    if (beats < CHAIN_LEN) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got %0d beats, expected %0d", beats, CHAIN_LEN);
    end
    chk("load_pulse_count", 32'(pulses), 32'(CHAIN_LEN));
    chk("load_stall_cnt", 32'(stall_cnt), 32'(stalls));
    if (mode == 1) chk("alt_stall_cnt", 32'(stall_cnt), 32'd7);
    chk("settle_first_done", 32'(done), 32'd0);
    chk("settle_first_cfg_en", 32'(config_enable), 32'd1);
    // Keep offering beats: none may be taken after the last one.
    s_valid = 1'b1;
    s_data  = ~exp_head;
    for (int i = 1; i <= SETTLE_CYC; i++) begin
      #2;
      chk("settle_ready", 32'(s_ready), 32'd0);
      tick();
      chk("settle_pulse", 32'(cfg_clk_en), 32'd0);
      chk("settle_head", 32'(ccff_head), 32'(exp_head));
      chk("settle_done", 32'(done), 32'(i == SETTLE_CYC));
      chk("settle_cfg_en", 32'(config_enable), 32'(i < SETTLE_CYC));
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [11:0] last_d;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 12'h5A3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h5A3, 16'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 12'hC3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC3C, 16'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 12'h777, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC3C, 16'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 12'h0F1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F1, 16'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F1, 16'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F1, 16'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F1, 16'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0F1, 16'd0};

    // Reset values
    tick();
    tick();
    chk("rst_head", 32'(ccff_head), 32'd0);
    chk("rst_cfg_clk_en", 32'(cfg_clk_en), 32'd0);
    chk("rst_cfg_en", 32'(config_enable), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    pReset = 1'b0;
    tick();

    // Table: start ignored while loading, stall, start+abort, abort with beat
    for (int r = 0; r < 10; r++) begin
      start   = tbl[r].st;
      abort   = tbl[r].ab;
      s_valid = tbl[r].v;
      s_data  = tbl[r].d;
      #2;
      chk($sformatf("tbl%0d_ready", r), 32'(s_ready), 32'(tbl[r].rdy));
      tick();
      chk($sformatf("tbl%0d_pulse", r), 32'(cfg_clk_en), 32'(tbl[r].cfg));
      chk($sformatf("tbl%0d_cfg_en", r), 32'(config_enable), 32'(tbl[r].ce));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].bsy));
      chk($sformatf("tbl%0d_done", r), 32'(done), 32'(tbl[r].dn));
      chk($sformatf("tbl%0d_aborted", r), 32'(aborted), 32'(tbl[r].abd));
      chk($sformatf("tbl%0d_head", r), 32'(ccff_head), 32'(tbl[r].head));
      chk($sformatf("tbl%0d_stall", r), 32'(stall_cnt), 32'(tbl[r].stall));
    end
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    tick();

    // Back-to-back load (also clears the sticky aborted flag), then alternating
    run_load(0);
    run_load(1);

    // Abort after three beats
    start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    last_d = '0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 12'($urandom_range(0, 4095));
      last_d  = s_data;
      tick();
      if (cfg_clk_en) pulses++;
    end
    s_data = ~last_d;
    abort  = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    if (cfg_clk_en) pulses++;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_aborted", 32'(aborted), 32'd1);
    chk("abort_cfg_en", 32'(config_enable), 32'd0);
    tick();
    if (cfg_clk_en) pulses++;
    chk("abort_pulses", 32'(pulses), 32'd3);
    chk("abort_head", 32'(ccff_head), 32'(last_d));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_restart_aborted", 32'(aborted), 32'd0);
    chk("abort_restart_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_settle_idle", 32'(busy), 32'd0);

    // Randomized loads
    for (int k = 0; k < 3; k++) run_load(2);

    // Asynchronous reset mid-load
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 12'hA5A;
      tick();
    end
    #2;
    pReset = 1'b1;
    #1;
    chk("arst_head", 32'(ccff_head), 32'd0);
    chk("arst_cfg_clk_en", 32'(cfg_clk_en), 32'd0);
    chk("arst_cfg_en", 32'(config_enable), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall_cnt), 32'd0);
    s_valid = 1'b0;
    tick();
    pReset = 1'b0;
    tick();
    run_load(0);

    // Long stall: stall_cnt saturates, no shifts
    start = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    pulses  = 0;
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (cfg_clk_en) pulses++;
      if (n == 65534) chk("stall_pre_sat", 32'(stall_cnt), 32'h0000FFFE);
      if (n == 65535) chk("stall_at_sat", 32'(stall_cnt), 32'h0000FFFF);
    end
    chk("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);
    chk("stall_no_pulses", 32'(pulses), 32'd0);
    chk("stall_still_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
